// File: rtl/nib_mult_pkg.sv
// nib_mult_pkg: shared widths and state encoding for the nibble-serial multiplier.
package nib_mult_pkg;
    localparam int NIB_W   = 4;
    localparam int SHIFT_W = 3;
    localparam int ACC_W   = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nib_mult_seq_if.sv
// nib_mult_seq_if: operand/product handshake plus the nibble datapath return loop.
interface nib_mult_seq_if #(parameter int N_NIB = 2);
    import nib_mult_pkg::*;
    logic                     start;
    logic [NIB_W*N_NIB-1:0]   op_a;
    logic [NIB_W*N_NIB-1:0]   op_b;
    logic [NIB_W-1:0]         nib_a;
    logic [NIB_W-1:0]         nib_b;
    logic [SHIFT_W-1:0]       shift_cntrl;
    logic [ACC_W-1:0]         shift_in;
    logic                     busy;
    logic                     done;
    logic [ACC_W-1:0]         product;
    modport master(output start, op_a, op_b, shift_in,
                   input nib_a, nib_b, shift_cntrl, busy, done, product);
    modport slave(input start, op_a, op_b, shift_in,
                  output nib_a, nib_b, shift_cntrl, busy, done, product);
endinterface

// File: rtl/nib_step_ctr.sv
// nib_step_ctr: nested nibble-index counter, i inner and j outer, with a last-step flag.
module nib_step_ctr #(parameter int N_NIB = 2) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [1:0] i,
    output logic [1:0] j,
    output logic       last
);
    localparam logic [1:0] MAX = 2'(N_NIB - 1);
    assign last = (i == MAX) && (j == MAX);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            i <= '0;
            j <= '0;
        end else if (en) begin
            i <= (i == MAX) ? '0 : i + 2'd1;
            j <= (i == MAX) ? ((j == MAX) ? '0 : j + 2'd1) : j;
        end
    end
endmodule

// File: rtl/nib_mult_seq.sv
// nib_mult_seq: walks nibble pairs through an external 4x4 multiplier and shifter,
// accumulating the shifted partial products into the final product.
module nib_mult_seq
    import nib_mult_pkg::*;
#(
    parameter int N_NIB = 2
) (
    input logic           clk,
    input logic           reset,
    nib_mult_seq_if.slave bus
);
    localparam int OP_W = NIB_W * N_NIB;
    state_t          state, state_n;
    logic [OP_W-1:0] a, b;
    logic [ACC_W-1:0] acc;
    logic [1:0]      i, j;
    logic            last, run, accept;
    assign run    = state == RUN;
    assign accept = bus.start && !run;
    nib_step_ctr #(.N_NIB(N_NIB)) u_ctr (
        .clk(clk), .reset(reset), .clear(accept), .en(run), .i(i), .j(j), .last(last)
    );
    always_comb begin
        state_n         = IDLE;
        bus.nib_a       = '0;
        bus.nib_b       = '0;
        bus.shift_cntrl = '0;
        bus.busy        = run;
        bus.done        = state == DONE;
        bus.product     = acc;
        if (accept) state_n = RUN;
        else if (run) state_n = last ? DONE : RUN;
        if (run) begin
            bus.nib_a       = NIB_W'(a >> (NIB_W * i));
            bus.nib_b       = NIB_W'(b >> (NIB_W * j));
            bus.shift_cntrl = SHIFT_W'(i) + SHIFT_W'(j);
        end
    end
    // acc stays frozen outside RUN, so it doubles as the held product
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                a   <= bus.op_a;
                b   <= bus.op_b;
                acc <= '0;
            end else if (run) begin
                acc <= acc + bus.shift_in;
            end
        end
    end
endmodule

// File: tb/tb_nib_mult_seq.sv
// tb_nib_mult_seq: scoreboard bench with behavioural 4x4 multiplier and shifter models.
module tb_nib_mult_seq;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  sc_q[$];
    logic [31:0] e;
    always #5 clk = ~clk;
    nib_mult_seq_if #(.N_NIB(2)) b2();
    nib_mult_seq_if #(.N_NIB(4)) b4();
    nib_mult_seq #(.N_NIB(2)) dut2(.clk(clk), .reset(reset), .bus(b2.slave));
    nib_mult_seq #(.N_NIB(4)) dut4(.clk(clk), .reset(reset), .bus(b4.slave));
    assign b2.shift_in = (32'(b2.nib_a) * 32'(b2.nib_b)) << {b2.shift_cntrl, 2'b00};
    assign b4.shift_in = (32'(b4.nib_a) * 32'(b4.nib_b)) << {b4.shift_cntrl, 2'b00};

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({b2.busy, b2.done, b4.busy, b4.done} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {b2.busy, b2.done, b4.busy, b4.done});
        end
        checks++;
        if (b2.product !== 32'h0 || b4.product !== 32'h0) begin
            failures++; $display("FAIL reset_product got=%h/%h want=0", b2.product, b4.product);
        end
        checks++;
        if ({b2.nib_a, b2.nib_b, b2.shift_cntrl} !== 11'h0) begin
            failures++; $display("FAIL reset_nibs got=%h want=0", {b2.nib_a, b2.nib_b, b2.shift_cntrl});
        end
        reset = 1'b0;
    endtask

    task automatic op2(input string nm, input logic [7:0] a, input logic [7:0] b);
        int lat = 1;
        int bcy = 0;
        @(negedge clk);
        b2.op_a = a; b2.op_b = b; b2.start = 1'b1;
        exp_q.push_back(32'(a) * 32'(b));
        @(negedge clk);
        b2.start = 1'b0;
        sc_q.delete();
        while (!b2.done && lat < 40) begin
            if (b2.busy) begin bcy++; sc_q.push_back(b2.shift_cntrl); end
            @(negedge clk); lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (!b2.done) begin
            failures++; $display("FAIL %s_timeout got=no done in %0d cycles want=done", nm, lat);
        end else begin
            checks++;
            if (lat !== 5) begin failures++; $display("FAIL %s_latency got=%0d want=5", nm, lat); end
            checks++;
            if (bcy !== 4) begin failures++; $display("FAIL %s_busy got=%0d want=4", nm, bcy); end
            checks++;
            if (b2.product !== e) begin failures++; $display("FAIL %s_product got=%h want=%h", nm, b2.product, e); end
            @(negedge clk);
            checks++;
            if (b2.done !== 1'b0 || b2.product !== e) begin
                failures++; $display("FAIL %s_after_done got done=%b product=%h want done=0 product=%h", nm, b2.done, b2.product, e);
            end
        end
    endtask

    task automatic test_ff();
        logic [11:0] got = '0;
        op2("ff", 8'hFF, 8'hFF);
        foreach (sc_q[k]) got = {got[8:0], sc_q[k]};
        checks++;
        if (sc_q.size() != 4 || got !== 12'b000_001_001_010) begin
            failures++; $display("FAIL ff_shift_seq got=%0d entries %b want=000001001010", sc_q.size(), got);
        end
    endtask

    task automatic test_basic();
        op2("basic", 8'h12, 8'h34);
    endtask

    task automatic test_start_in_run();
        int lat = 1;
        @(negedge clk);
        b2.op_a = 8'h21; b2.op_b = 8'h13; b2.start = 1'b1;
        exp_q.push_back(32'h21 * 32'h13);
        @(negedge clk);
        b2.op_a = 8'hAA; b2.op_b = 8'h55;
        @(negedge clk); lat++;
        b2.start = 1'b0;
        while (!b2.done && lat < 40) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        checks++;
        if (!b2.done || lat !== 5) begin
            failures++; $display("FAIL ignore_start_latency got=%0d done=%b want=5", lat, b2.done);
        end
        checks++;
        if (b2.product !== e) begin failures++; $display("FAIL ignore_start_product got=%h want=%h", b2.product, e); end
    endtask

    task automatic test_back_to_back();
        int lat = 1;
        @(negedge clk);
        b2.op_a = 8'h07; b2.op_b = 8'h09; b2.start = 1'b1;
        exp_q.push_back(32'h07 * 32'h09);
        @(negedge clk);
        b2.start = 1'b0;
        repeat (3) @(negedge clk);
        b2.op_a = 8'h03; b2.op_b = 8'h05; b2.start = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (b2.done !== 1'b1 || b2.product !== e) begin
            failures++; $display("FAIL b2b_first got done=%b product=%h want done=1 product=%h", b2.done, b2.product, e);
        end
        exp_q.push_back(32'h03 * 32'h05);
        @(negedge clk);
        b2.start = 1'b0;
        checks++;
        if (b2.busy !== 1'b1 || b2.done !== 1'b0) begin
            failures++; $display("FAIL b2b_no_idle got busy=%b done=%b want busy=1 done=0", b2.busy, b2.done);
        end
        while (!b2.done && lat < 40) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        checks++;
        if (!b2.done || lat !== 5 || b2.product !== e) begin
            failures++; $display("FAIL b2b_second got done=%b lat=%0d product=%h want done=1 lat=5 product=%h", b2.done, lat, b2.product, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        @(negedge clk);
        b2.op_a = 8'h77; b2.op_b = 8'h66; b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (b2.busy !== 1'b0 || b2.done !== 1'b0 || b2.product !== 32'h0) begin
            failures++; $display("FAIL abort_state got busy=%b done=%b product=%h want 0/0/0", b2.busy, b2.done, b2.product);
        end
        repeat (10) begin @(negedge clk); if (b2.done) dones++; end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses want=0", dones); end
        op2("recover", 8'h10, 8'h10);
    endtask

    task automatic test_n4();
        int lat = 1;
        int bcy = 0;
        logic [6:0] cov = '0;
        @(negedge clk);
        b4.op_a = 16'hFFFF; b4.op_b = 16'hFFFF; b4.start = 1'b1;
        exp_q.push_back(32'hFFFF * 32'hFFFF);
        @(negedge clk);
        b4.start = 1'b0;
        while (!b4.done && lat < 60) begin
            if (b4.busy) begin bcy++; cov[b4.shift_cntrl] = 1'b1; end
            @(negedge clk); lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (!b4.done || lat !== 17) begin failures++; $display("FAIL n4_latency got=%0d done=%b want=17", lat, b4.done); end
        checks++;
        if (bcy !== 16) begin failures++; $display("FAIL n4_busy got=%0d want=16", bcy); end
        checks++;
        if (cov !== 7'h7F) begin failures++; $display("FAIL n4_shift_cover got=%b want=1111111", cov); end
        checks++;
        if (b4.product !== e) begin failures++; $display("FAIL n4_product got=%h want=%h", b4.product, e); end
    endtask

    initial begin
        reset = 1'b1;
        b2.start = 1'b0; b2.op_a = '0; b2.op_b = '0;
        b4.start = 1'b0; b4.op_a = '0; b4.op_b = '0;
        test_reset();
        test_ff();
        test_basic();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_n4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
